counter_scheduler: RTL and testbench
====================================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter: WIDTH, 4, bit width of the shared count register and of each length field.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  2  per-requester level request; bit i belongs to requester i.
REQ-005 Port: len  input  2*WIDTH  target counts; len[WIDTH-1:0] for requester 0, len[2*WIDTH-1:WIDTH] for requester 1.
REQ-006 Port: gnt  output  2  one-hot grant; all-zero when no requester owns the counter.
REQ-007 Port: done  output  2  one-cycle completion pulse, one bit per requester.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.
REQ-009 Port: q  output  WIDTH  current value of the shared count register.
REQ-010 All outputs SHALL be registered or decoded from registered state only; no combinational path from req or len to any output.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-012 IDLE, no req bit set: SHALL stay in IDLE.
REQ-013 IDLE, any req bit set: SHALL pick a winner, latch the winner's len field into an internal target, set q <= 0, and enter LOAD.
REQ-014 Winner selection: single requester wins outright; if both bits are set, the requester named by a 1-bit round-robin pointer wins.
REQ-015 gnt[winner] SHALL be high in LOAD and RUN, and low in IDLE and DONE.
REQ-016 LOAD SHALL go to RUN unconditionally after one cycle, with q held at 0.
REQ-017 RUN, q != target: SHALL set q <= q + 1 and stay in RUN.
REQ-018 RUN, q == target: SHALL enter DONE with q held.
REQ-019 target == 0 SHALL complete through LOAD -> RUN -> DONE with q never leaving 0.
REQ-020 q SHALL never wrap, since target <= 2^WIDTH-1 and counting stops at target.
REQ-021 Latency: req sampled in IDLE at cycle N -> gnt at N+1 -> done[winner] pulse at N+3+target.
REQ-022 DONE SHALL last exactly one cycle with done[winner]=1, SHALL return to IDLE, and SHALL set the pointer to the other requester.
REQ-023 Abort: in LOAD or RUN, if req[winner] is sampled low, the next state SHALL be IDLE with gnt=0, no done pulse, q <= 0, and the pointer set to the other requester.
REQ-024 Changes to len after the winner is chosen SHALL be ignored until the next grant.
REQ-025 Requests during LOAD, RUN or DONE from the non-granted requester SHALL be held off; they are serviced no earlier than the first cycle back in IDLE.
REQ-026 A requester holding req high continuously SHALL NOT be granted twice in a row while the other requester is also requesting.

Reset
REQ-027 With reset high at a rising edge: state <= IDLE, q <= 0, gnt <= 0, done <= 0, busy <= 0, pointer <= 0 (requester 0 has priority), target <= 0.
REQ-028 Reset SHALL override any state, including mid-RUN and DONE: no done pulse is produced, and the next cycle after reset falls is IDLE.
REQ-029 Reset SHALL take precedence over all requests sampled in the same cycle.

Verification
REQ-030 Single run: after reset, req=01, len[3:0]=3 held -> gnt=01 for cycles 1-5; q reads 0,0,1,2,3; done=01 on cycle 6 only; busy low on cycle 7.
REQ-031 Zero length: req=10, len[7:4]=0 -> gnt=10 for 2 cycles, q stays 0, done=10 at cycle 3.
REQ-032 Contention: req=11 from reset, both lengths 2 -> requester 0 completes first, requester 1 is granted the cycle after returning to IDLE, and grants then alternate 0,1,0,1.
REQ-033 Abort: requester 0 with len=9 drops req when q=4 -> next cycle IDLE, gnt=00, q=0, no done; with req=11 the following grant goes to requester 1.
REQ-034 Reset mid-operation: reset pulsed for one cycle while q=5 in RUN -> the following cycle shows q=0, gnt=00, busy=0, no done pulse, and requester 0 has priority again.
REQ-035 Max length: len=15 -> q counts 0..15 without wrap, and done arrives at cycle 18 after the request was sampled.

Source files
------------

// File: rtl/counter_scheduler.sv
// Two-requester scheduler that grants one shared up-counter at a time.
// The winner's count runs from 0 to its latched length, then a done pulse is issued.
module counter_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [2*WIDTH-1:0] len,
   output logic [1:0]         gnt,
   output logic [1:0]         done,
   output logic               busy,
   output logic [WIDTH-1:0]   q
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             win_q, win_d;
   logic             ptr_q, ptr_d;
   logic             pick;

   // With both bits set, the round-robin pointer names the winner.
   always_comb begin
      if (req == 2'b11) pick = ptr_q;
      else              pick = req[1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         win_q    <= 1'b0;
         ptr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         win_q    <= win_d;
         ptr_q    <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      win_d    = win_q;
      ptr_d    = ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               win_d    = pick;
               target_d = pick ? len[2*WIDTH-1:WIDTH] : len[WIDTH-1:0];
               cnt_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (!req[win_q]) begin
               state_d = IDLE;
               cnt_d   = '0;
               ptr_d   = ~win_q;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Dropping the request wins over reaching the target.
            if (!req[win_q]) begin
               state_d = IDLE;
               cnt_d   = '0;
               ptr_d   = ~win_q;
            end else if (cnt_q == target_q) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = ~win_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt  = 2'b00;
      done = 2'b00;
      busy = (state_q != IDLE);
      if (state_q == LOAD || state_q == RUN) gnt[win_q] = 1'b1;
      if (state_q == DONE) done[win_q] = 1'b1;
   end

   assign q = cnt_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: directed literal scenarios plus randomized traffic
// compared every cycle against a grant-age behavioural model.
module tb_counter_scheduler;
   localparam int W = 4;

   logic           clk;
   logic           reset;
   logic [1:0]     req;
   logic [2*W-1:0] len;
   logic [1:0]     gnt;
   logic [1:0]     done;
   logic           busy;
   logic [W-1:0]   q;

   int checks   = 0;
   int failures = 0;

   counter_scheduler #(.WIDTH(W)) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .len  (len),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .q    (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   // Model: an owner plus the number of cycles since its grant began.
   // Ages 0..tgt+1 are the granted cycles (count shown is max(age-1,0)),
   // age tgt+2 is the completion cycle.
   int  m_owner = -1;
   int  m_age   = 0;
   int  m_tgt   = 0;
   int  m_ptr   = 0;
   int  m_qidle = 0;
   bit  armed   = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_qidle = 0;
         armed   = 1'b1;
      end else if (m_owner < 0) begin
         if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
            m_tgt   = (m_owner == 1) ? int'(len[2*W-1:W]) : int'(len[W-1:0]);
            m_age   = 0;
         end
      end else if (m_age <= m_tgt + 1) begin
         if (!req[m_owner]) begin
            m_ptr   = 1 - m_owner;
            m_owner = -1;
            m_qidle = 0;
         end else begin
            m_age++;
         end
      end else begin
         m_ptr   = 1 - m_owner;
         m_qidle = m_tgt;
         m_owner = -1;
      end
   end

   always @(negedge clk) begin
      logic [1:0]   eg, ed;
      logic         eb;
      logic [W-1:0] eq;
      if (armed) begin
         eg = 2'b00;
         ed = 2'b00;
         eb = 1'b0;
         eq = W'(m_qidle);
         if (m_owner >= 0) begin
            eb = 1'b1;
            if (m_age <= m_tgt + 1) begin
               eg = 2'(1 << m_owner);
               eq = (m_age <= 1) ? W'(0) : W'(m_age - 1);
            end else begin
               ed = 2'(1 << m_owner);
               eq = W'(m_tgt);
            end
         end
         chk("model_gnt", 32'(gnt), 32'(eg));
         chk("model_done", 32'(done), 32'(ed));
         chk("model_busy", 32'(busy), 32'(eb));
         chk("model_q", 32'(q), 32'(eq));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 2'b00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_q(input logic [W-1:0] v, input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q == v) begin
            found = 1'b1;
            break;
         end
      end
      chk(name, 32'(found), 32'd1);
   endtask

   initial begin
      int gstart[$];
      int gowner[$];
      logic [1:0] prev_g;
      reset = 1'b1;
      req   = 2'b00;
      len   = '0;
      do_reset();
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_q", 32'(q), 32'd0);

      // Single run, length 3 on requester 0
      req = 2'b01;
      len = {4'd0, 4'd3};
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k <= 5) chk("run3_gnt", 32'(gnt), 32'd1);
         if (k == 1) chk("run3_q1", 32'(q), 32'd0);
         if (k == 2) chk("run3_q2", 32'(q), 32'd0);
         if (k == 3) chk("run3_q3", 32'(q), 32'd1);
         if (k == 5) chk("run3_q5", 32'(q), 32'd3);
         if (k == 5) chk("run3_nodone5", 32'(done), 32'd0);
         if (k == 6) chk("run3_done", 32'(done), 32'd1);
         if (k == 6) chk("run3_gnt6", 32'(gnt), 32'd0);
         if (k == 7) chk("run3_busy7", 32'(busy), 32'd0);
         if (k == 7) chk("run3_done7", 32'(done), 32'd0);
      end
      req = 2'b00;

      // Zero length on requester 1
      do_reset();
      req = 2'b10;
      len = {4'd0, 4'd7};
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k <= 2) chk("zero_gnt", 32'(gnt), 32'd2);
         chk("zero_q", 32'(q), 32'd0);
         if (k == 3) chk("zero_done", 32'(done), 32'd2);
      end
      req = 2'b00;

      // Maximum length
      do_reset();
      req = 2'b01;
      len = {4'd9, 4'd15};
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 17) chk("max_q17", 32'(q), 32'd15);
         if (k == 17) chk("max_nodone17", 32'(done), 32'd0);
         if (k == 18) chk("max_done18", 32'(done), 32'd1);
         if (k == 18) chk("max_q18", 32'(q), 32'd15);
      end
      req = 2'b00;

      // Contention: both request length 2, grants must alternate every 6 cycles
      do_reset();
      req = 2'b11;
      len = {4'd2, 4'd2};
      prev_g = 2'b00;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (gnt != 2'b00 && prev_g == 2'b00) begin
            gstart.push_back(k);
            gowner.push_back(gnt[1] ? 1 : 0);
         end
         prev_g = gnt;
      end
      for (int i = 0; i < 4; i++) begin
         chk("rr_owner", (i < gowner.size()) ? 32'(gowner[i]) : 32'hFFFF_FFFF, 32'(i % 2));
         chk("rr_start", (i < gstart.size()) ? 32'(gstart[i]) : 32'hFFFF_FFFF, 32'(1 + 6 * i));
      end
      req = 2'b00;

      // Abort requester 0 at q=4, then requester 1 must win the tie
      do_reset();
      req = 2'b11;
      len = {4'd1, 4'd9};
      wait_q(4'd4, "abort_reach_q4");
      req = 2'b10;
      @(negedge clk);
      chk("abort_gnt", 32'(gnt), 32'd0);
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      req = 2'b11;
      @(negedge clk);
      chk("abort_next_gnt", 32'(gnt), 32'd2);
      req = 2'b00;

      // Reset mid-run at q=5, priority returns to requester 0
      do_reset();
      req = 2'b01;
      len = {4'd3, 4'd9};
      wait_q(4'd5, "rst_reach_q5");
      reset = 1'b1;
      req   = 2'b11;
      @(negedge clk);
      chk("midrst_q", 32'(q), 32'd0);
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_prio", 32'(gnt), 32'd1);
      req = 2'b00;

      // Randomized traffic, mostly-held requests with occasional drops and resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req[0] = ($urandom_range(0, 99) < 85);
         req[1] = ($urandom_range(0, 99) < 85);
         if ($urandom_range(0, 7) == 0) len = 8'($urandom);
         reset = ($urandom_range(0, 149) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      req   = 2'b00;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
